mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative signed 32x32 multiply / 32/32 divide unit for the
//                EX stage. The operation runs on operand magnitudes for 32
//                cycles (shift-add for MUL, restoring shift-subtract for DIV).
//                One further cycle applies the signs, and then the result is
//                presented for one cycle with a done pulse.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start, alu_control - request and opcode (0101 MUL, 1011 DIV)
//                operand_a/b       - signed operands
//                stall             - combinational pipeline freeze request
//                busy, done        - registered status
//                result_lo/hi      - MUL product lo/hi, DIV quotient/remainder
//                div_by_zero       - divide-by-zero flag, valid with done
//  Config      : MUL_DIV_EARLY_OUT_EN - when defined, a divide by zero or a
//                multiply by zero finishes directly, without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  alu_control,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        div_by_zero
);
    localparam logic [3:0] c_op_mul    = 4'b0101;
    localparam logic [3:0] c_op_div    = 4'b1011;
    localparam logic [4:0] c_last_iter = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_count;
    logic        r_is_mul;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div_zero;
    logic [31:0] r_hi;      // MUL: partial product high; DIV: partial remainder
    logic [31:0] r_lo;      // MUL: multiplier / product low; DIV: dividend / quotient
    logic [31:0] r_mag;     // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;

    logic        w_op_mul;
    logic        w_op_div;
    logic        w_accept;
    logic        w_early;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_sub;
    logic        w_div_ge;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_op_mul = (alu_control == c_op_mul);
    assign w_op_div = (alu_control == c_op_div);
    assign w_accept = start && (w_op_mul || w_op_div) &&
                      ((r_state == IDLE) || (r_state == DONE));

`ifdef MUL_DIV_EARLY_OUT_EN
    assign w_early  = w_accept &&
                      ((operand_b == 32'd0) || (w_op_mul && (operand_a == 32'd0)));
`else
    assign w_early  = 1'b0;
`endif

    // Negating 0x80000000 yields 0x80000000, which read as unsigned is 2^31.
    assign w_abs_a = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    assign w_abs_b = operand_b[31] ? (32'd0 - operand_b) : operand_b;

    // Shift-add step: carry out of the high half is shifted back in.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : 33'd0);

    // Restoring step: the shifted remainder is always below 2^32, so bit 32
    // of the 33-bit difference is the borrow.
    assign w_div_shift = {r_hi, r_lo[31]};
    assign w_div_sub   = w_div_shift - {1'b0, r_mag};
    assign w_div_ge    = ~w_div_sub[32];

    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (32'd0 - r_lo) : r_lo;
    assign w_rem_fix  = r_sign_a ? (32'd0 - r_hi) : r_hi;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_early ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_count == c_last_iter) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_is_mul   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mag      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
        end else begin
            r_busy <= (w_state_nxt == CALC) || (w_state_nxt == FIX);
            r_done <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_count    <= '0;
                r_is_mul   <= w_op_mul;
                r_sign_a   <= operand_a[31];
                r_sign_b   <= operand_b[31];
                r_div_zero <= w_op_div && (operand_b == 32'd0);
                r_hi       <= '0;
                r_lo       <= w_op_mul ? w_abs_b : w_abs_a;
                r_mag      <= w_op_mul ? w_abs_a : w_abs_b;
`ifdef MUL_DIV_EARLY_OUT_EN
                // Early-out results are final at once: zero product, or the
                // divide-by-zero pattern.
                if (w_early) begin
                    r_res_lo <= w_op_mul ? 32'd0 : 32'hFFFF_FFFF;
                    r_res_hi <= w_op_mul ? 32'd0 : operand_a;
                    r_dbz    <= w_op_div;
                end
`endif
            end else if (r_state == CALC) begin
                r_count <= r_count + 5'd1;
                if (r_is_mul) begin
                    r_hi <= w_mul_sum[32:1];
                    r_lo <= {w_mul_sum[0], r_lo[31:1]};
                end else begin
                    r_hi <= w_div_ge ? w_div_sub[31:0] : w_div_shift[31:0];
                    r_lo <= {r_lo[30:0], w_div_ge};
                end
            end else if (r_state == FIX) begin
                r_dbz <= ~r_is_mul & r_div_zero;
                if (r_is_mul) begin
                    {r_res_hi, r_res_lo} <= w_prod_fix;
                end else begin
                    // With a zero divisor the remainder path has already
                    // reproduced the dividend; only the quotient is forced.
                    r_res_lo <= r_div_zero ? 32'hFFFF_FFFF : w_quo_fix;
                    r_res_hi <= w_rem_fix;
                end
            end
        end
    end

    assign stall       = ~reset & (r_busy | (w_accept && (r_state == IDLE)));
    assign busy        = r_busy;
    assign done        = r_done;
    assign result_lo   = r_res_lo;
    assign result_hi   = r_res_hi;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit. Covers the
//                signed MUL/DIV vectors, latency and busy/stall/done timing,
//                back-to-back issue from DONE, ignored requests, divide by
//                zero, the most-negative operand cases and reset behaviour.
//                Honours MUL_DIV_EARLY_OUT_EN for the zero-operand latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    localparam logic [3:0] c_op_mul  = 4'b0101;
    localparam logic [3:0] c_op_div  = 4'b1011;
    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam int         c_lat_full = 34;
`ifdef MUL_DIV_EARLY_OUT_EN
    localparam int         c_lat_zero = 1;
`else
    localparam int         c_lat_zero = 34;
`endif
    localparam int         c_timeout  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_seen;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request in the current cycle (cycle 0) and check stall.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start       = 1'b1;
        alu_control = ctl;
        operand_a   = a;
        operand_b   = b;
        #1;
        check({tag, " stall c0"}, 64'(stall), 64'(exp_stall));
    endtask

    // Follow an issued operation up to its DONE cycle; returns in that cycle.
    // With noise set, a competing MUL request is raised mid-calculation.
    task automatic wait_done(input logic [31:0] elo, input logic [31:0] ehi, input logic edbz,
                             input int elat, input bit noise, input string tag);
        int cyc;
        tick;
        start       = 1'b0;
        alu_control = 4'b0000;
        cyc = 1;
        while (done !== 1'b1 && cyc < c_timeout) begin
            check($sformatf("%s busy c%0d", tag, cyc), 64'(busy), 64'(cyc < elat));
            check($sformatf("%s stall c%0d", tag, cyc), 64'(stall), 64'(cyc < elat));
            if (noise && cyc == 5) begin
                start       = 1'b1;
                alu_control = c_op_mul;
                operand_a   = 32'd1;
                operand_b   = 32'd1;
            end
            if (noise && cyc == 6) begin
                start       = 1'b0;
                alu_control = 4'b0000;
            end
            tick;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " stall@done"}, 64'(stall), 64'd0);
        check({tag, " lo"}, 64'(result_lo), 64'(elo));
        check({tag, " hi"}, 64'(result_hi), 64'(ehi));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
    endtask

    // Leave DONE without a new request: done must drop and the results hold.
    task automatic settle(input logic [31:0] elo, input logic [31:0] ehi, input string tag);
        tick;
        check({tag, " done drop"}, 64'(done), 64'd0);
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " lo hold"}, 64'(result_lo), 64'(elo));
        check({tag, " hi hold"}, 64'(result_hi), 64'(ehi));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        alu_control = 4'b0000;
        operand_a   = 32'd0;
        operand_b   = 32'd0;
        tick;
        tick;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst lo", 64'(result_lo), 64'd0);
        check("rst hi", 64'(result_hi), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);

        // Reset wins over a valid start in the same cycle.
        start = 1'b1; alu_control = c_op_mul; operand_a = 32'd3; operand_b = 32'd4;
        #1;
        check("rst prio stall", 64'(stall), 64'd0);
        tick;
        check("rst prio busy", 64'(busy), 64'd0);
        check("rst prio done", 64'(done), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        tick;

        // 7 x -3 = -21
        issue(c_op_mul, 32'd7, 32'hFFFF_FFFD, 1'b1, "mul 7x-3");
        wait_done(32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, c_lat_full, 1'b0, "mul 7x-3");
        settle(32'hFFFF_FFEB, 32'hFFFF_FFFF, "mul 7x-3");

        // -7 / 2 = -3 rem -1
        issue(c_op_div, 32'hFFFF_FFF9, 32'd2, 1'b1, "div -7/2");
        wait_done(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, c_lat_full, 1'b0, "div -7/2");
        settle(32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2");

        // 7 / -2 = -3 rem 1, with an ignored MUL request during CALC
        issue(c_op_div, 32'd7, 32'hFFFF_FFFE, 1'b1, "div 7/-2");
        wait_done(32'hFFFF_FFFD, 32'd1, 1'b0, c_lat_full, 1'b1, "div 7/-2");
        settle(32'hFFFF_FFFD, 32'd1, "div 7/-2");

        // 0x12345678 x 16 = 0x1_23456780
        issue(c_op_mul, 32'h1234_5678, 32'd16, 1'b1, "mul big");
        wait_done(32'h2345_6780, 32'd1, 1'b0, c_lat_full, 1'b0, "mul big");
        settle(32'h2345_6780, 32'd1, "mul big");

        // 100 / 0
        issue(c_op_div, 32'd100, 32'd0, 1'b1, "div 100/0");
        wait_done(32'hFFFF_FFFF, 32'd100, 1'b1, c_lat_zero, 1'b0, "div 100/0");
        settle(32'hFFFF_FFFF, 32'd100, "div 100/0");

        // 0 x 5: zero product, div_by_zero cleared for a MUL
        issue(c_op_mul, 32'd0, 32'd5, 1'b1, "mul 0x5");
        wait_done(32'd0, 32'd0, 1'b0, c_lat_zero, 1'b0, "mul 0x5");
        settle(32'd0, 32'd0, "mul 0x5");

        // 0x80000000 squared, then a DIV issued in the DONE cycle
        issue(c_op_mul, 32'h8000_0000, 32'h8000_0000, 1'b1, "mul min^2");
        wait_done(32'd0, 32'h4000_0000, 1'b0, c_lat_full, 1'b0, "mul min^2");
        issue(c_op_div, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
        wait_done(32'h8000_0000, 32'd0, 1'b0, c_lat_full, 1'b0, "div min/-1");
        settle(32'h8000_0000, 32'd0, "div min/-1");

        // A non-MUL/DIV code is ignored
        issue(c_op_add, 32'd5, 32'd6, 1'b0, "add ignored");
        tick;
        start = 1'b0;
        alu_control = 4'b0000;
        check("add ignored busy", 64'(busy), 64'd0);
        check("add ignored done", 64'(done), 64'd0);
        tick;
        check("add ignored busy2", 64'(busy), 64'd0);

        // Abort a DIV with reset in cycle 10
        issue(c_op_div, 32'd1000, 32'd7, 1'b1, "div abort");
        tick;
        start = 1'b0;
        alu_control = 4'b0000;
        repeat (9) tick;
        check("abort busy c10", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort stall in rst", 64'(stall), 64'd0);
        tick;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort stall", 64'(stall), 64'd0);
        check("abort lo", 64'(result_lo), 64'd0);
        check("abort hi", 64'(result_hi), 64'd0);
        check("abort dbz", 64'(div_by_zero), 64'd0);
        done_seen = 0;
        repeat (40) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("abort no done/busy", 64'(done_seen), 64'd0);

        // Fresh operation after reset
        issue(c_op_div, 32'd9, 32'd3, 1'b1, "div 9/3");
        wait_done(32'd3, 32'd0, 1'b0, c_lat_full, 1'b0, "div 9/3");
        settle(32'd3, 32'd0, "div 9/3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
